// File: rtl/pipeline_hazard_unit.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_unit
//   Hazard unit on the consumer side of the pipelined controller. It watches
//   the staged EX/MEM/WB control and destination registers plus the ID source
//   registers. It drives the signals that go back up the pipe: PC/IF-ID hold,
//   ID/EX bubble, wrong-path flushes and the ALU forwarding selects. It also
//   keeps saturating stall/flush event counters for debug.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   id_rs, id_rt, id_uses_rt source registers of the ID instruction
//   ex_rs, ex_rt             source registers of the EX instruction
//   ex_memread, ex_dst       load in EX and its write register
//   mem_regwrite, mem_dst    MEM writeback info
//   mem_redirect             taken branch/jump resolved in MEM
//   wb_regwrite, wb_dst      WB writeback info
//   pc_hold, idex_bubble     load-use stall controls
//   flush_ifid/idex/exmem    wrong-path flushes
//   fwd_a, fwd_b             ALU operand selects (00 regfile, 10 MEM, 01 WB)
//   stall_count, flush_count saturating event counters
// ---------------------------------------------------------------------------
module pipeline_hazard_unit #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic [REG_W-1:0] ex_rs,
   input  logic [REG_W-1:0] ex_rt,
   input  logic             ex_memread,
   input  logic [REG_W-1:0] ex_dst,
   input  logic             mem_regwrite,
   input  logic [REG_W-1:0] mem_dst,
   input  logic             mem_redirect,
   input  logic             wb_regwrite,
   input  logic [REG_W-1:0] wb_dst,
   output logic             pc_hold,
   output logic             idex_bubble,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             flush_exmem,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   // SHADOW marks the one cycle after a redirect, when the instruction in ID
   // is a wrong-path remnant that must not be allowed to trigger a stall.
   typedef enum logic {RUN = 1'b0, SHADOW = 1'b1} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic [CNT_W-1:0] flush_count_q, flush_count_d;
   logic             load_use;

   // Register 0 is hardwired, so it can never create a dependency.
   always_comb begin
      load_use = ex_memread && (ex_dst != '0) &&
                 ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));
   end

   always_comb begin
      state_d       = state_q;
      stall_count_d = stall_count_q;
      flush_count_d = flush_count_q;
      pc_hold       = 1'b0;
      idex_bubble   = 1'b0;
      flush_ifid    = 1'b0;
      flush_idex    = 1'b0;
      flush_exmem   = 1'b0;
      if (rst) begin
         // Outputs stay quiet; state and counters are cleared by the flops.
         state_d = RUN;
      end else if (mem_redirect) begin
         // Redirect wins over any stall, in either state.
         flush_ifid  = 1'b1;
         flush_idex  = 1'b1;
         flush_exmem = 1'b1;
         state_d     = SHADOW;
         if (flush_count_q != CNT_MAX) flush_count_d = flush_count_q + CNT_ONE;
      end else begin
         case (state_q)
            RUN: begin
               pc_hold     = load_use;
               idex_bubble = load_use;
               if (load_use && (stall_count_q != CNT_MAX))
                  stall_count_d = stall_count_q + CNT_ONE;
            end
            SHADOW:  state_d = RUN;
            default: state_d = RUN;
         endcase
      end
   end

   // Forwarding is independent of the FSM; MEM is the newer value so it wins.
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (!rst) begin
         if (mem_regwrite && (mem_dst != '0) && (mem_dst == ex_rs))   fwd_a = 2'b10;
         else if (wb_regwrite && (wb_dst != '0) && (wb_dst == ex_rs)) fwd_a = 2'b01;
         if (mem_regwrite && (mem_dst != '0) && (mem_dst == ex_rt))   fwd_b = 2'b10;
         else if (wb_regwrite && (wb_dst != '0) && (wb_dst == ex_rt)) fwd_b = 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= RUN;
         stall_count_q <= '0;
         flush_count_q <= '0;
      end else begin
         state_q       <= state_d;
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   assign stall_count = stall_count_q;
   assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// ---------------------------------------------------------------------------
// Bench for pipeline_hazard_unit. Two instances share the stimulus: one with
// default 16-bit counters, one with 4-bit counters to reach saturation. The
// driver computes each cycle's expected response from the behavioural rules
// and queues it; a monitor pops and compares a quarter cycle later.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_unit;

   typedef struct {
      logic       rst;
      logic [4:0] id_rs, id_rt;
      logic       id_uses_rt;
      logic [4:0] ex_rs, ex_rt;
      logic       ex_memread;
      logic [4:0] ex_dst;
      logic       mem_regwrite;
      logic [4:0] mem_dst;
      logic       mem_redirect;
      logic       wb_regwrite;
      logic [4:0] wb_dst;
   } stim_t;

   typedef struct {
      logic [8:0] ctl;     // {hold, bubble, f_ifid, f_idex, f_exmem, fwd_a, fwd_b}
      bit         cnt_known;
      int         stall, flush;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
   logic       id_uses_rt, ex_memread, mem_regwrite, mem_redirect, wb_regwrite;

   logic        pc_hold, idex_bubble, flush_ifid, flush_idex, flush_exmem;
   logic [1:0]  fwd_a, fwd_b;
   logic [15:0] stall_count, flush_count;
   logic        pc_hold4, idex_bubble4, flush_ifid4, flush_idex4, flush_exmem4;
   logic [1:0]  fwd_a4, fwd_b4;
   logic [3:0]  stall_count4, flush_count4;

   always #5 clk = ~clk;

   pipeline_hazard_unit #(.REG_W(5), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_memread(ex_memread), .ex_dst(ex_dst),
      .mem_regwrite(mem_regwrite), .mem_dst(mem_dst), .mem_redirect(mem_redirect),
      .wb_regwrite(wb_regwrite), .wb_dst(wb_dst), .pc_hold(pc_hold),
      .idex_bubble(idex_bubble), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
      .flush_exmem(flush_exmem), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .stall_count(stall_count), .flush_count(flush_count));

   pipeline_hazard_unit #(.REG_W(5), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_memread(ex_memread), .ex_dst(ex_dst),
      .mem_regwrite(mem_regwrite), .mem_dst(mem_dst), .mem_redirect(mem_redirect),
      .wb_regwrite(wb_regwrite), .wb_dst(wb_dst), .pc_hold(pc_hold4),
      .idex_bubble(idex_bubble4), .flush_ifid(flush_ifid4), .flush_idex(flush_idex4),
      .flush_exmem(flush_exmem4), .fwd_a(fwd_a4), .fwd_b(fwd_b4),
      .stall_count(stall_count4), .flush_count(flush_count4));

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   // reference model state
   bit in_shadow = 1'b0;
   bit cnt_known = 1'b0;
   int m_stall = 0, m_flush = 0;

   function automatic stim_t idle();
      stim_t s;
      s.rst = 1'b0; s.id_rs = '0; s.id_rt = '0; s.id_uses_rt = 1'b0;
      s.ex_rs = '0; s.ex_rt = '0; s.ex_memread = 1'b0; s.ex_dst = '0;
      s.mem_regwrite = 1'b0; s.mem_dst = '0; s.mem_redirect = 1'b0;
      s.wb_regwrite = 1'b0; s.wb_dst = '0;
      return s;
   endfunction

   function automatic logic [1:0] fwd_sel(input stim_t s, input logic [4:0] src);
      if (s.mem_regwrite && s.mem_dst != 0 && s.mem_dst == src) return 2'b10;
      if (s.wb_regwrite && s.wb_dst != 0 && s.wb_dst == src)    return 2'b01;
      return 2'b00;
   endfunction

   function automatic int sat(input int v, input int max);
      return (v > max) ? max : v;
   endfunction

   task automatic step(input stim_t s);
      exp_t e;
      bit   lu, hold, fl;
      @(negedge clk);
      rst = s.rst; id_rs = s.id_rs; id_rt = s.id_rt; id_uses_rt = s.id_uses_rt;
      ex_rs = s.ex_rs; ex_rt = s.ex_rt; ex_memread = s.ex_memread; ex_dst = s.ex_dst;
      mem_regwrite = s.mem_regwrite; mem_dst = s.mem_dst; mem_redirect = s.mem_redirect;
      wb_regwrite = s.wb_regwrite; wb_dst = s.wb_dst;
      lu   = s.ex_memread && s.ex_dst != 0 &&
             (s.ex_dst == s.id_rs || (s.id_uses_rt && s.ex_dst == s.id_rt));
      fl   = !s.rst && s.mem_redirect;
      hold = !s.rst && !s.mem_redirect && !in_shadow && lu;
      e.ctl = {hold, hold, fl, fl, fl,
               s.rst ? 2'b00 : fwd_sel(s, s.ex_rs),
               s.rst ? 2'b00 : fwd_sel(s, s.ex_rt)};
      e.cnt_known = cnt_known;
      e.stall = m_stall;
      e.flush = m_flush;
      sb.push_back(e);
      // advance model to the next edge
      if (s.rst) begin
         in_shadow = 1'b0; m_stall = 0; m_flush = 0; cnt_known = 1'b1;
      end else if (fl) begin
         in_shadow = 1'b1; m_flush++;
      end else begin
         if (hold) m_stall++;
         in_shadow = 1'b0;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: every cycle is an output cycle for this block
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ctl16", {23'b0, pc_hold, idex_bubble, flush_ifid, flush_idex,
                          flush_exmem, fwd_a, fwd_b}, {23'b0, e.ctl});
            chk("ctl4", {23'b0, pc_hold4, idex_bubble4, flush_ifid4, flush_idex4,
                         flush_exmem4, fwd_a4, fwd_b4}, {23'b0, e.ctl});
            if (e.cnt_known) begin
               chk("stall16", {16'b0, stall_count}, sat(e.stall, 65535));
               chk("flush16", {16'b0, flush_count}, sat(e.flush, 65535));
               chk("stall4", {28'b0, stall_count4}, sat(e.stall, 15));
               chk("flush4", {28'b0, flush_count4}, sat(e.flush, 15));
            end
         end
      end
   end

   initial begin
      stim_t s, hit;
      int    guard;
      rst = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_rs = '0; ex_rt = '0;
      ex_memread = 1'b0; ex_dst = '0; mem_regwrite = 1'b0; mem_dst = '0;
      mem_redirect = 1'b0; wb_regwrite = 1'b0; wb_dst = '0;

      // reset held with a load-use hit present
      s = idle(); s.rst = 1'b1; s.ex_memread = 1'b1; s.ex_dst = 5; s.id_rs = 5;
      step(s); step(s);
      s.rst = 1'b0; step(s);
      step(idle());

      // load-use on rt, then no stall without rt use, then none with r0
      s = idle(); s.ex_memread = 1'b1; s.ex_dst = 8; s.id_rs = 3; s.id_rt = 8; s.id_uses_rt = 1'b1;
      step(s); step(idle());
      s.id_uses_rt = 1'b0; step(s);
      s.id_uses_rt = 1'b1; s.ex_dst = 0; s.id_rt = 0; step(s);

      // redirect beats stall; shadow cycle ignores the hit; then stall resumes
      hit = idle(); hit.ex_memread = 1'b1; hit.ex_dst = 9; hit.id_rs = 9;
      s = hit; s.mem_redirect = 1'b1; step(s);
      step(hit); step(hit); step(idle());

      // forwarding priority
      s = idle(); s.ex_rs = 7; s.mem_dst = 7; s.wb_dst = 7;
      s.mem_regwrite = 1'b1; s.wb_regwrite = 1'b1; step(s);
      s.mem_regwrite = 1'b0; step(s);
      s.ex_rt = 7; s.mem_regwrite = 1'b1; step(s);
      s.mem_regwrite = 1'b0; step(s);
      s.mem_regwrite = 1'b1; s.mem_dst = 0; s.wb_dst = 0; step(s);

      // three back-to-back redirects, then leave SHADOW
      s = idle(); s.mem_redirect = 1'b1;
      step(s); step(s); step(s);
      step(hit); step(hit); step(idle());

      // saturation of the 4-bit counters
      for (int i = 0; i < 20; i++) begin
         step(hit); step(idle());
      end
      for (int i = 0; i < 20; i++) begin
         s = idle(); s.mem_redirect = 1'b1; step(s);
      end
      step(idle());

      // mid-stall reset
      step(hit); s = hit; s.rst = 1'b1; step(s); step(hit);

      // randomized traffic with small register space to provoke hits
      for (int i = 0; i < 600; i++) begin
         s.rst          = ($urandom_range(0, 49) == 0);
         s.id_rs        = 5'($urandom_range(0, 3));
         s.id_rt        = 5'($urandom_range(0, 3));
         s.id_uses_rt   = 1'($urandom_range(0, 1));
         s.ex_rs        = 5'($urandom_range(0, 3));
         s.ex_rt        = 5'($urandom_range(0, 3));
         s.ex_memread   = 1'($urandom_range(0, 1));
         s.ex_dst       = 5'($urandom_range(0, 3));
         s.mem_regwrite = 1'($urandom_range(0, 1));
         s.mem_dst      = 5'($urandom_range(0, 3));
         s.mem_redirect = ($urandom_range(0, 5) == 0);
         s.wb_regwrite  = 1'($urandom_range(0, 1));
         s.wb_dst       = 5'($urandom_range(0, 3));
         step(s);
      end

      guard = 0;
      while (sb.size() > 0 && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      if (sb.size() > 0) begin
         checks++; errors++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
- Consumer side of the pipelined controller's staged control outputs.
- Observes the EX, MEM and WB control and destination-register information the controller pipelines down the datapath, together with ID-stage source registers.
- Drives the signals that travel back up the pipeline: PC/IF-ID hold, ID/EX bubble, wrong-path flushes, and ALU operand forwarding selects.
- Keeps saturating stall and flush event counters for debug.

Parameters:
- REG_W, 5, register-index width.
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  REG_W  rs field of the instruction in ID.
- id_rt  in  REG_W  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt: R-type, beq, bneq, sw.
- ex_rs  in  REG_W  rs of the instruction in EX.
- ex_rt  in  REG_W  rt of the instruction in EX.
- ex_memread  in  1  MemRead in EX stage.
- ex_dst  in  REG_W  resolved write register in EX, after RegDest mux.
- mem_regwrite  in  1  RegWrite3.
- mem_dst  in  REG_W  write register in MEM.
- mem_redirect  in  1  PCsrc3 OR J_type3: control transfer taken in MEM.
- wb_regwrite  in  1  RegWrite4.
- wb_dst  in  REG_W  write register in WB.
- pc_hold  out  1  PC and IF/ID keep their value.
- idex_bubble  out  1  zero all control into ID/EX.
- flush_ifid  out  1  clear IF/ID.
- flush_idex  out  1  clear ID/EX.
- flush_exmem  out  1  clear EX/MEM control.
- fwd_a  out  2  ALU A select: 00 regfile, 10 MEM result, 01 WB result.
- fwd_b  out  2  same encoding for ALU B.
- stall_count  out  CNT_W  load-use stalls taken.
- flush_count  out  CNT_W  redirects taken.

Behaviour:
- FSM states: RUN and SHADOW. Reset enters RUN.
- Reset values: stall_count=0, flush_count=0. While rst=1, all 1-bit outputs are forced to 0 and fwd_a=fwd_b=00.
- load_use is combinational: ex_memread=1 AND ex_dst≠0 AND (ex_dst==id_rs OR (id_uses_rt AND ex_dst==id_rt)).
- Redirect has priority over everything else. If mem_redirect=1 in any state:
  - flush_ifid=flush_idex=flush_exmem=1 in the same cycle;
  - pc_hold=0 and idex_bubble=0;
  - flush_count increments, saturating at all-ones;
  - next state is SHADOW.
- RUN without redirect:
  - pc_hold=idex_bubble=load_use;
  - if load_use, stall_count increments (saturating);
  - state stays RUN.
  - A load-use stall lasts exactly 1 cycle: next cycle the load is in MEM and load_use clears naturally. Back-to-back loads may produce consecutive stalls, one count each.
- SHADOW without redirect:
  - the ID instruction is a wrong-path remnant, so load_use is ignored;
  - pc_hold=idex_bubble=0, no count;
  - next state is RUN.
- SHADOW with redirect again: same as the redirect rule; flushes fire, state stays SHADOW.
- Forwarding (combinational, never gated by the FSM):
  - fwd_a=10 if mem_regwrite AND mem_dst≠0 AND mem_dst==ex_rs;
  - else fwd_a=01 if wb_regwrite AND wb_dst≠0 AND wb_dst==ex_rs;
  - else fwd_a=00.
  - fwd_b uses ex_rt with the same rules.
  - MEM wins over WB when both match.
- Register 0 never stalls and never forwards.
- Counters saturate and do not wrap. They are cleared only by reset.
- Reset asserted mid-stall or in SHADOW: the next cycle is RUN with all counters 0.
- Latency: all hold, bubble, flush and forward outputs are same-cycle (Mealy). Only state and counters are registered.

Test Plan:
- Reset: hold rst=1 for 2 cycles with ex_memread=1 and ex_dst=id_rs=5 → all outputs 0, counts 0. After release → pc_hold=idex_bubble=1, stall_count=1 at the next edge.
- Load-use on rt: ex_memread=1, ex_dst=8, id_rs=3, id_rt=8, id_uses_rt=1 → 1-cycle stall. Repeat with id_uses_rt=0 → no stall. Repeat with ex_dst=0 → no stall.
- Redirect beats stall: mem_redirect=1 together with a load_use hit → all three flushes=1, pc_hold=0, flush_count+1, stall_count unchanged. Next cycle, load_use still true → no stall (SHADOW). The cycle after → stall resumes.
- Forwarding priority: mem_dst=wb_dst=ex_rs=7, both regwrites=1 → fwd_a=10. Drop mem_regwrite → 01. Set ex_rt=7 → fwd_b follows the same sequence. Set dst=0 → 00.
- Back-to-back redirects on 3 consecutive cycles → flushes every cycle, flush_count=3, state ends SHADOW, then RUN one cycle after the last redirect.
- Saturation: with CNT_W=4, drive 20 load-use cycles separated by non-hits → stall_count sticks at 15.
